// File: rtl/knight_pkg.sv
// Shared types and move geometry for the parametrised knight-tour solver.
// A move is a one-hot byte; off_x/off_y give its signed displacement.
package knight_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      POSSIBLE,
      MAKE_MOVE,
      BACKUP
   } state_t;

   localparam logic [7:0] MV_0 = 8'h01;
   localparam logic [7:0] MV_1 = 8'h02;
   localparam logic [7:0] MV_2 = 8'h04;
   localparam logic [7:0] MV_3 = 8'h08;
   localparam logic [7:0] MV_4 = 8'h10;
   localparam logic [7:0] MV_5 = 8'h20;
   localparam logic [7:0] MV_6 = 8'h40;
   localparam logic [7:0] MV_7 = 8'h80;

   function automatic logic signed [2:0] off_x(input logic [7:0] mv);
      case (mv)
         MV_0:    off_x = -3'sd1;
         MV_1:    off_x =  3'sd1;
         MV_2:    off_x = -3'sd2;
         MV_3:    off_x = -3'sd2;
         MV_4:    off_x = -3'sd1;
         MV_5:    off_x =  3'sd1;
         MV_6:    off_x =  3'sd2;
         MV_7:    off_x =  3'sd2;
         default: off_x =  3'sd0;
      endcase
   endfunction

   function automatic logic signed [2:0] off_y(input logic [7:0] mv);
      case (mv)
         MV_0:    off_y =  3'sd2;
         MV_1:    off_y =  3'sd2;
         MV_2:    off_y =  3'sd1;
         MV_3:    off_y = -3'sd1;
         MV_4:    off_y = -3'sd2;
         MV_5:    off_y = -3'sd2;
         MV_6:    off_y = -3'sd1;
         MV_7:    off_y =  3'sd1;
         default: off_y =  3'sd0;
      endcase
   endfunction

endpackage

// File: rtl/knight_poss_calc.sv
// Combinational legal-move mask: bit k is set when move k from (xx,yy)
// lands on the board without wrapping and on an unvisited square.
module knight_poss_calc
   import knight_pkg::*;
#(
   parameter int BOARD_W = 5,
   parameter int BOARD_H = 5,
   localparam int CW  = $clog2((BOARD_W > BOARD_H ? BOARD_W : BOARD_H) + 1),
   localparam int NSQ = BOARD_W * BOARD_H
) (
   input  logic [CW-1:0]  xx_i,
   input  logic [CW-1:0]  yy_i,
   input  logic [NSQ-1:0] visited_i,
   output logic [7:0]     poss_o
);

   // Signed integer arithmetic makes off-board targets negative or too large
   // instead of wrapping, so the range test alone rejects them.
   always_comb begin
      logic [7:0] mv;
      int         tx;
      int         ty;
      int         sq;
      logic       occ;
      poss_o = '0;
      mv     = '0;
      tx     = 0;
      ty     = 0;
      sq     = 0;
      occ    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         mv  = 8'h01 << k;
         tx  = int'(xx_i) + int'(off_x(mv));
         ty  = int'(yy_i) + int'(off_y(mv));
         sq  = ty * BOARD_W + tx;
         occ = 1'b0;
         for (int s = 0; s < NSQ; s++) begin
            if (s == sq) occ = visited_i[s];
         end
         if (tx >= 0 && tx < BOARD_W && ty >= 0 && ty < BOARD_H && !occ)
            poss_o[k] = 1'b1;
      end
   end

endmodule

// File: rtl/knight_tour_param.sv
// Depth-first backtracking knight's-tour solver for a BOARD_W x BOARD_H board.
// Signals done on a complete tour, fail on exhaustion or an off-board start.
module knight_tour_param
   import knight_pkg::*;
#(
   parameter int BOARD_W = 5,
   parameter int BOARD_H = 5,
   localparam int NUM_MOVES = BOARD_W * BOARD_H - 1,
   localparam int CW = $clog2((BOARD_W > BOARD_H ? BOARD_W : BOARD_H) + 1),
   localparam int IW = (NUM_MOVES > 0) ? $clog2(NUM_MOVES + 1) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   input  logic          abort,
   input  logic [CW-1:0] x_start,
   input  logic [CW-1:0] y_start,
   input  logic [IW-1:0] indx,
   output logic          done,
   output logic          fail,
   output logic          busy,
   output logic [7:0]    move
);

   localparam int NSQ   = BOARD_W * BOARD_H;
   localparam int DEPTH = 2 ** IW;

   state_t         state_q;
   logic [NSQ-1:0] visited_q;
   logic [7:0]     lastMove_q [DEPTH];
   logic [7:0]     poss_q     [DEPTH];
   logic [CW-1:0]  xx_q;
   logic [CW-1:0]  yy_q;
   logic [CW-1:0]  xs_q;
   logic [CW-1:0]  ys_q;
   logic [IW-1:0]  moveNum_q;
   logic [7:0]     moveTry_q;
   logic           done_q;
   logic           fail_q;

   logic [7:0]     possMask_d;
   logic [7:0]     prevMove_d;
   logic [IW-1:0]  nextNum_d;
   logic [CW-1:0]  fwdX_d;
   logic [CW-1:0]  fwdY_d;
   logic [CW-1:0]  backX_d;
   logic [CW-1:0]  backY_d;
   int             fwdIdx_d;
   int             curIdx_d;
   int             startIdx_d;

   knight_poss_calc #(
      .BOARD_W(BOARD_W),
      .BOARD_H(BOARD_H)
   ) u_poss (
      .xx_i     (xx_q),
      .yy_i     (yy_q),
      .visited_i(visited_q),
      .poss_o   (possMask_d)
   );

   // Forward target of the candidate and the square we came from on backup.
   always_comb begin
      prevMove_d = lastMove_q[moveNum_q - 1'b1];
      nextNum_d  = moveNum_q + 1'b1;
      fwdX_d     = CW'(int'(xx_q) + int'(off_x(moveTry_q)));
      fwdY_d     = CW'(int'(yy_q) + int'(off_y(moveTry_q)));
      backX_d    = CW'(int'(xx_q) - int'(off_x(prevMove_d)));
      backY_d    = CW'(int'(yy_q) - int'(off_y(prevMove_d)));
      fwdIdx_d   = int'(fwdY_d) * BOARD_W + int'(fwdX_d);
      curIdx_d   = int'(yy_q) * BOARD_W + int'(xx_q);
      startIdx_d = int'(ys_q) * BOARD_W + int'(xs_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         visited_q <= '0;
         xx_q      <= '0;
         yy_q      <= '0;
         xs_q      <= '0;
         ys_q      <= '0;
         moveNum_q <= '0;
         moveTry_q <= '0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            lastMove_q[i] <= '0;
            poss_q[i]     <= '0;
         end
      end else begin
         done_q <= 1'b0;
         fail_q <= 1'b0;
         // Abort wins over everything, even the cycle that would finish the tour.
         if (abort && state_q != IDLE) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (go) begin
                     visited_q <= '0;
                     moveNum_q <= '0;
                     xs_q      <= x_start;
                     ys_q      <= y_start;
                     for (int i = 0; i < DEPTH; i++) lastMove_q[i] <= '0;
                     if (x_start >= BOARD_W || y_start >= BOARD_H) fail_q <= 1'b1;
                     else state_q <= INIT;
                  end
               end
               INIT: begin
                  xx_q <= xs_q;
                  yy_q <= ys_q;
                  for (int s = 0; s < NSQ; s++)
                     if (s == startIdx_d) visited_q[s] <= 1'b1;
                  if (NUM_MOVES == 0) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     state_q <= POSSIBLE;
                  end
               end
               POSSIBLE: begin
                  poss_q[moveNum_q] <= possMask_d;
                  moveTry_q         <= MV_0;
                  state_q           <= MAKE_MOVE;
               end
               MAKE_MOVE: begin
                  if ((moveTry_q & poss_q[moveNum_q]) != 8'h00) begin
                     lastMove_q[moveNum_q] <= moveTry_q;
                     xx_q      <= fwdX_d;
                     yy_q      <= fwdY_d;
                     moveNum_q <= nextNum_d;
                     for (int s = 0; s < NSQ; s++)
                        if (s == fwdIdx_d) visited_q[s] <= 1'b1;
                     if (nextNum_d == IW'(NUM_MOVES)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                     end else begin
                        state_q <= POSSIBLE;
                     end
                  end else if (moveTry_q != MV_7) begin
                     moveTry_q <= moveTry_q << 1;
                  end else begin
                     state_q <= BACKUP;
                  end
               end
               BACKUP: begin
                  if (moveNum_q == '0) begin
                     fail_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     for (int s = 0; s < NSQ; s++)
                        if (s == curIdx_d) visited_q[s] <= 1'b0;
                     xx_q      <= backX_d;
                     yy_q      <= backY_d;
                     moveNum_q <= moveNum_q - 1'b1;
                     if (prevMove_d != MV_7) begin
                        moveTry_q <= prevMove_d << 1;
                        state_q   <= MAKE_MOVE;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign done = done_q;
   assign fail = fail_q;
   assign busy = (state_q != IDLE);
   assign move = (int'(indx) < NUM_MOVES) ? lastMove_q[indx] : 8'h00;

endmodule

// File: tb/tb_knight_tour_param.sv
// Directed bench for knight_tour_param: a 5x5 solver plus 3x3 and 1x1 instances
// for exhaustion and the trivial board; every expectation is worked out by hand.
`timescale 1ns/10ps
module tb_knight_tour_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       go = 1'b0, abort = 1'b0;
   logic [2:0] xStart = '0, yStart = '0;
   logic [4:0] indx = '0;
   logic       done, fail, busy;
   logic [7:0] move;

   logic       go3 = 1'b0, abort3 = 1'b0;
   logic [1:0] xStart3 = '0, yStart3 = '0;
   logic [3:0] indx3 = '0;
   logic       done3, fail3, busy3;
   logic [7:0] move3;

   logic       go1 = 1'b0, abort1 = 1'b0;
   logic [0:0] xStart1 = '0, yStart1 = '0;
   logic [0:0] indx1 = '0;
   logic       done1, fail1, busy1;
   logic [7:0] move1;

   int checks = 0;
   int errors = 0;
   int dxTab [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
   int dyTab [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

   knight_tour_param dut (
      .clk(clk), .rst(rst), .go(go), .abort(abort), .x_start(xStart), .y_start(yStart),
      .indx(indx), .done(done), .fail(fail), .busy(busy), .move(move)
   );

   knight_tour_param #(.BOARD_W(3), .BOARD_H(3)) dut3 (
      .clk(clk), .rst(rst), .go(go3), .abort(abort3), .x_start(xStart3), .y_start(yStart3),
      .indx(indx3), .done(done3), .fail(fail3), .busy(busy3), .move(move3)
   );

   knight_tour_param #(.BOARD_W(1), .BOARD_H(1)) dut1 (
      .clk(clk), .rst(rst), .go(go1), .abort(abort1), .x_start(xStart1), .y_start(yStart1),
      .indx(indx1), .done(done1), .fail(fail1), .busy(busy1), .move(move1)
   );

   always #5 clk = ~clk;

   // One comparison: count it and report any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse go on the 5x5 solver; returns at the negedge after go was sampled.
   task automatic applyStimulus(input logic [2:0] x, input logic [2:0] y);
      @(negedge clk);
      xStart = x;
      yStart = y;
      go     = 1'b1;
      @(negedge clk);
      go     = 1'b0;
   endtask

   initial begin
      int cyc;
      int pulses;
      int bad;
      int px, py, k;
      int nonZero;
      logic [24:0] vis;
      logic [7:0]  m;

      // Reset state
      #3;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_fail", fail, 0);
      checkOutput("rst_move", move, 0);
      checkOutput("rst_busy3", busy3, 0);
      checkOutput("rst_busy1", busy1, 0);
      @(negedge clk);
      rst = 1'b0;

      // Out-of-range start column: fail right after go, never busy
      applyStimulus(3'd5, 3'd0);
      checkOutput("oor_fail", fail, 1);
      checkOutput("oor_busy", busy, 0);
      checkOutput("oor_done", done, 0);
      @(negedge clk);
      checkOutput("oor_fail_width", fail, 0);
      checkOutput("oor_busy_after", busy, 0);

      // 3x3 centre: INIT, POSSIBLE, 8 rejected candidates, BACKUP -> fail 12 cycles after go
      @(negedge clk);
      xStart3 = 2'd1; yStart3 = 2'd1; go3 = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         go3 = 1'b0;
         cyc++;
      end while (!(fail3 || done3) && cyc < 40);
      checkOutput("c3_latency", cyc, 12);
      checkOutput("c3_fail", fail3, 1);
      checkOutput("c3_done", done3, 0);
      checkOutput("c3_busy", busy3, 0);

      // 3x3 corner: ring of 8 squares never reaches the centre, so exhaustive fail
      @(negedge clk);
      xStart3 = 2'd0; yStart3 = 2'd0; go3 = 1'b1;
      cyc = 0;
      pulses = 0;
      do begin
         @(negedge clk);
         go3 = 1'b0;
         cyc++;
         if (done3) pulses++;
      end while (!fail3 && cyc < 5000);
      checkOutput("c3c_timeout", (cyc < 5000), 1);
      checkOutput("c3c_fail", fail3, 1);
      checkOutput("c3c_no_done", pulses, 0);

      // 1x1 board: INIT then done
      @(negedge clk);
      go1 = 1'b1;
      @(negedge clk);
      go1 = 1'b0;
      checkOutput("b1_busy_init", busy1, 1);
      checkOutput("b1_done_early", done1, 0);
      @(negedge clk);
      checkOutput("b1_done", done1, 1);
      checkOutput("b1_fail", fail1, 0);
      checkOutput("b1_busy_end", busy1, 0);
      @(negedge clk);
      checkOutput("b1_done_width", done1, 0);
      checkOutput("b1_move", move1, 0);

      // Abort 50 cycles after go
      applyStimulus(3'd0, 3'd0);
      pulses = 0;
      repeat (49) begin
         @(negedge clk);
         if (done || fail) pulses++;
      end
      checkOutput("abort_busy_before", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      if (done || fail) pulses++;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_pulses", pulses, 0);
      indx = 5'd0;
      #1;
      checkOutput("abort_move0", move, 8'h02);
      @(negedge clk);
      checkOutput("abort_no_pulse", done | fail, 0);

      // Full 5x5 solve from (0,0) with go held high for several busy cycles
      @(negedge clk);
      xStart = 3'd0; yStart = 3'd0; go = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("hold_busy", busy, 1);
      go = 1'b0;
      cyc = 0;
      while (!(done || fail) && cyc < 90000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("solve_timeout", (cyc < 90000), 1);
      checkOutput("solve_done", done, 1);
      checkOutput("solve_fail", fail, 0);
      checkOutput("solve_busy", busy, 0);
      @(negedge clk);
      checkOutput("solve_done_width", done, 0);

      // Replay the recorded tour with the bench's own offset table
      px = 0; py = 0; bad = 0;
      vis = 25'd1;
      for (int i = 0; i < 24; i++) begin
         indx = 5'(i);
         #1;
         m = move;
         if (!$onehot(m)) begin
            bad++;
         end else begin
            k = 0;
            for (int b = 0; b < 8; b++) if (m[b]) k = b;
            px = px + dxTab[k];
            py = py + dyTab[k];
            if (px < 0 || px > 4 || py < 0 || py > 4) bad++;
            else if (vis[py*5+px]) bad++;
            else vis[py*5+px] = 1'b1;
         end
      end
      checkOutput("tour_bad_moves", bad, 0);
      checkOutput("tour_squares", $countones(vis), 25);
      indx = 5'd24;
      #1;
      checkOutput("move_idx24", move, 0);
      indx = 5'd31;
      #1;
      checkOutput("move_idx31", move, 0);

      // Asynchronous reset in the middle of a solve
      applyStimulus(3'd0, 3'd0);
      repeat (30) @(negedge clk);
      checkOutput("mid_busy_before", busy, 1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_done", done, 0);
      checkOutput("arst_fail", fail, 0);
      nonZero = 0;
      for (int i = 0; i < 25; i++) begin
         indx = 5'(i);
         #0.1;
         if (move != 8'h00) nonZero++;
      end
      checkOutput("arst_moves", nonZero, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("arst_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
